// File: rtl/access_ctrl_param_if.sv
// Digit-entry, credential-ROM and status bundle for access_ctrl_param.
// The slave modport is the controller; the master modport is the keypad/ROM/game side.
interface access_ctrl_param_if #(
  parameter int DIGIT_W     = 4,
  parameter int USER_DIGITS = 4,
  parameter int PASS_DIGITS = 5,
  parameter int ADDR_W      = 3,
  parameter int MAX_FAIL    = 3
);
  localparam int UW  = USER_DIGITS * DIGIT_W;
  localparam int PW  = PASS_DIGITS * DIGIT_W;
  localparam int FCW = $clog2(MAX_FAIL + 1);

  logic [DIGIT_W-1:0] digit_in;
  logic               digit_strobe;
  logic               logout;
  logic [ADDR_W-1:0]  rom_addr;
  logic [UW-1:0]      rom_user;
  logic [PW-1:0]      rom_pass;
  logic               granted;
  logic [ADDR_W-1:0]  user_idx;
  logic               fail_pulse;
  logic               locked;
  logic [FCW-1:0]     fail_count;
  logic               pass_phase;

  modport master (
    output digit_in, digit_strobe, logout, rom_user, rom_pass,
    input  rom_addr, granted, user_idx, fail_pulse, locked, fail_count, pass_phase
  );

  modport slave (
    input  digit_in, digit_strobe, logout, rom_user, rom_pass,
    output rom_addr, granted, user_idx, fail_pulse, locked, fail_count, pass_phase
  );
endinterface

// File: rtl/access_ctrl_param.sv
// Credential checker gating the memory game: user ID + password entry, ROM search, lockout.
// Optional idle-entry abort is enabled by defining ACCESS_ENTRY_TIMEOUT_EN.
module access_ctrl_param #(
  parameter int DIGIT_W        = 4,
  parameter int USER_DIGITS    = 4,
  parameter int PASS_DIGITS    = 5,
  parameter int NUM_USERS      = 8,
  parameter int ADDR_W         = 3,
  parameter int MAX_FAIL       = 3,
  parameter int LOCK_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic clk,
  input  logic rst,
  access_ctrl_param_if.slave bus
);
  localparam int UW   = USER_DIGITS * DIGIT_W;
  localparam int PW   = PASS_DIGITS * DIGIT_W;
  localparam int FCW  = $clog2(MAX_FAIL + 1);
  localparam int MAXD = (USER_DIGITS > PASS_DIGITS) ? USER_DIGITS : PASS_DIGITS;
  localparam int CW   = $clog2(MAXD + 1);
  localparam int LW   = $clog2(LOCK_CYCLES + 1);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_USERS - 1);
  localparam logic [CW-1:0]     USER_LAST = CW'(USER_DIGITS - 1);
  localparam logic [CW-1:0]     PASS_LAST = CW'(PASS_DIGITS - 1);
  localparam logic [FCW-1:0]    FAIL_MAX  = FCW'(MAX_FAIL);
  localparam logic [LW-1:0]     LOCK_LOAD = LW'(LOCK_CYCLES - 1);

  if (NUM_USERS < 1 || (1 << ADDR_W) < NUM_USERS) begin : g_bad_rom
    $error("access_ctrl_param: ROM depth does not fit ADDR_W");
  end
  if (MAX_FAIL < 1 || LOCK_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_limits
    $error("access_ctrl_param: MAX_FAIL, LOCK_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_ENTER_USER,
    S_SEARCH,
    S_ENTER_PASS,
    S_FETCH,
    S_CHECK,
    S_GRANTED,
    S_LOCKOUT
  } state_t;

  state_t            r_state;
  logic [UW-1:0]     r_user;
  logic [PW-1:0]     r_pass;
  logic [CW-1:0]     r_digit_cnt;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [ADDR_W-1:0] r_cmp_idx;
  logic              r_cmp_valid;
  logic [ADDR_W-1:0] r_cand;
  logic              r_match;
  logic              r_granted;
  logic [ADDR_W-1:0] r_user_idx;
  logic              r_fail_pulse;
  logic              r_locked;
  logic [FCW-1:0]    r_fail_count;
  logic              r_pass_phase;
  logic [LW-1:0]     r_lock_cnt;
`ifdef ACCESS_ENTRY_TIMEOUT_EN
  localparam int            TW           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0]            r_idle_cnt;
`endif

  logic           w_user_hit;
  logic           w_pass_ok;
  logic [FCW-1:0] w_fail_next;

  // rom_user/rom_pass always belong to the address presented one cycle earlier.
  assign w_user_hit  = r_cmp_valid && (bus.rom_user == r_user);
  assign w_pass_ok   = r_match && (bus.rom_pass == r_pass);
  assign w_fail_next = r_fail_count + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_ENTER_USER;
      r_user       <= '0;
      r_pass       <= '0;
      r_digit_cnt  <= '0;
      r_rom_addr   <= '0;
      r_cmp_idx    <= '0;
      r_cmp_valid  <= 1'b0;
      r_cand       <= '0;
      r_match      <= 1'b0;
      r_granted    <= 1'b0;
      r_user_idx   <= '0;
      r_fail_pulse <= 1'b0;
      r_locked     <= 1'b0;
      r_fail_count <= '0;
      r_pass_phase <= 1'b0;
      r_lock_cnt   <= '0;
`ifdef ACCESS_ENTRY_TIMEOUT_EN
      r_idle_cnt   <= '0;
`endif
    end else begin
      r_fail_pulse <= 1'b0;
      unique case (r_state)
        S_ENTER_USER: begin
          if (bus.digit_strobe) begin
            r_user <= (r_user << DIGIT_W) | UW'(bus.digit_in);
`ifdef ACCESS_ENTRY_TIMEOUT_EN
            r_idle_cnt <= '0;
`endif
            if (r_digit_cnt == USER_LAST) begin
              r_digit_cnt <= '0;
              r_rom_addr  <= '0;
              r_cmp_valid <= 1'b0;
              r_state     <= S_SEARCH;
            end else begin
              r_digit_cnt <= r_digit_cnt + 1'b1;
            end
          end
`ifdef ACCESS_ENTRY_TIMEOUT_EN
          else if (r_digit_cnt != '0) begin
            if (r_idle_cnt == TIMEOUT_LAST) begin
              r_user      <= '0;
              r_digit_cnt <= '0;
              r_idle_cnt  <= '0;
            end else begin
              r_idle_cnt <= r_idle_cnt + 1'b1;
            end
          end
`endif
        end

        S_SEARCH: begin
          // Unknown users still proceed to password entry so IDs are not revealed.
          if (w_user_hit || (r_cmp_valid && r_cmp_idx == LAST_IDX)) begin
            r_cand       <= r_cmp_idx;
            r_match      <= w_user_hit;
            r_pass_phase <= 1'b1;
            r_state      <= S_ENTER_PASS;
`ifdef ACCESS_ENTRY_TIMEOUT_EN
            r_idle_cnt   <= '0;
`endif
          end else begin
            r_cmp_valid <= 1'b1;
            r_cmp_idx   <= r_rom_addr;
            if (r_rom_addr != LAST_IDX) begin
              r_rom_addr <= r_rom_addr + 1'b1;
            end
          end
        end

        S_ENTER_PASS: begin
          if (bus.digit_strobe) begin
            r_pass <= (r_pass << DIGIT_W) | PW'(bus.digit_in);
`ifdef ACCESS_ENTRY_TIMEOUT_EN
            r_idle_cnt <= '0;
`endif
            if (r_digit_cnt == PASS_LAST) begin
              r_digit_cnt  <= '0;
              r_rom_addr   <= r_cand;
              r_pass_phase <= 1'b0;
              r_state      <= S_FETCH;
            end else begin
              r_digit_cnt <= r_digit_cnt + 1'b1;
            end
          end
`ifdef ACCESS_ENTRY_TIMEOUT_EN
          else if (r_idle_cnt == TIMEOUT_LAST) begin
            r_user       <= '0;
            r_pass       <= '0;
            r_digit_cnt  <= '0;
            r_idle_cnt   <= '0;
            r_pass_phase <= 1'b0;
            r_state      <= S_ENTER_USER;
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
`endif
        end

        S_FETCH: r_state <= S_CHECK;

        S_CHECK: begin
          r_user <= '0;
          r_pass <= '0;
          if (w_pass_ok) begin
            r_granted    <= 1'b1;
            r_user_idx   <= r_cand;
            r_fail_count <= '0;
            r_state      <= S_GRANTED;
          end else begin
            r_fail_pulse <= 1'b1;
            r_fail_count <= w_fail_next;
            if (w_fail_next == FAIL_MAX) begin
              r_locked   <= 1'b1;
              r_lock_cnt <= LOCK_LOAD;
              r_state    <= S_LOCKOUT;
            end else begin
              r_state <= S_ENTER_USER;
            end
          end
        end

        S_GRANTED: begin
          if (bus.logout) begin
            r_granted  <= 1'b0;
            r_user_idx <= '0;
            r_state    <= S_ENTER_USER;
          end
        end

        S_LOCKOUT: begin
          if (r_lock_cnt == '0) begin
            r_fail_count <= '0;
            r_locked     <= 1'b0;
            r_state      <= S_ENTER_USER;
          end else begin
            r_lock_cnt <= r_lock_cnt - 1'b1;
          end
        end

        default: r_state <= S_ENTER_USER;
      endcase
    end
  end

  assign bus.rom_addr   = r_rom_addr;
  assign bus.granted    = r_granted;
  assign bus.user_idx   = r_user_idx;
  assign bus.fail_pulse = r_fail_pulse;
  assign bus.locked     = r_locked;
  assign bus.fail_count = r_fail_count;
  assign bus.pass_phase = r_pass_phase;
endmodule

// File: tb/tb_access_ctrl_param.sv
// Scoreboard bench for access_ctrl_param: stimulus queues expected grant/logout/reject/unlock
// events, a negedge monitor pops and compares them as the controller produces them.
module tb_access_ctrl_param;
  localparam int DIGIT_W = 4;
  localparam int UD      = 4;
  localparam int PD      = 5;
  localparam int NU      = 8;
  localparam int AW      = 3;
  localparam int MF      = 3;
  localparam int LOCK    = 20;
  localparam int TMO     = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  access_ctrl_param_if #(
    .DIGIT_W(DIGIT_W), .USER_DIGITS(UD), .PASS_DIGITS(PD), .ADDR_W(AW), .MAX_FAIL(MF)
  ) bus ();

  access_ctrl_param #(
    .DIGIT_W(DIGIT_W), .USER_DIGITS(UD), .PASS_DIGITS(PD), .NUM_USERS(NU), .ADDR_W(AW),
    .MAX_FAIL(MF), .LOCK_CYCLES(LOCK), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Synchronous credential ROM: data appears one cycle after the address.
  logic [15:0] rom_u [NU];
  logic [19:0] rom_p [NU];
  initial begin
    rom_u[0] = 16'h1111; rom_p[0] = 20'h11111;
    rom_u[1] = 16'h2222; rom_p[1] = 20'h22222;
    rom_u[2] = 16'h1A2B; rom_p[2] = 20'h3C4D5;
    rom_u[3] = 16'h4444; rom_p[3] = 20'h44444;
    rom_u[4] = 16'h5555; rom_p[4] = 20'h55555;
    rom_u[5] = 16'h1A2B; rom_p[5] = 20'h55555;
    rom_u[6] = 16'h6666; rom_p[6] = 20'h66666;
    rom_u[7] = 16'h7777; rom_p[7] = 20'h77777;
  end
  always @(posedge clk) begin
    bus.rom_user <= rom_u[bus.rom_addr];
    bus.rom_pass <= rom_p[bus.rom_addr];
  end

  typedef enum int {EV_GRANT, EV_LOGOUT, EV_REJECT, EV_UNLOCK} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       idx;
    int       fcount;
    int       aux;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic push(input ev_kind_t k, input int idx, input int fc, input int aux);
    exp_t e;
    e.kind = k; e.idx = idx; e.fcount = fc; e.aux = aux;
    sb_q.push_back(e);
  endtask

  // Monitor
  logic prev_g = 1'b0;
  logic prev_l = 1'b0;
  int   lock_len = 0;

  task automatic ev(input ev_kind_t k);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_event: got %s, expected no event", k.name());
    end else begin
      e = sb_q.pop_front();
      chk("event_kind", int'(k), int'(e.kind));
      case (k)
        EV_GRANT: begin
          chk("grant_user_idx", int'(bus.user_idx), e.idx);
          chk("grant_fail_count", int'(bus.fail_count), e.fcount);
        end
        EV_LOGOUT: chk("logout_user_idx", int'(bus.user_idx), 0);
        EV_REJECT: begin
          chk("reject_fail_count", int'(bus.fail_count), e.fcount);
          chk("reject_locked", int'(bus.locked), e.aux);
        end
        EV_UNLOCK: begin
          chk("lock_length", lock_len, e.aux);
          chk("unlock_fail_count", int'(bus.fail_count), e.fcount);
        end
        default: ;
      endcase
      $display("txn %s idx=%0d fail_count=%0d locked=%0d lock_len=%0d", k.name(),
               bus.user_idx, bus.fail_count, bus.locked, lock_len);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_g   = 1'b0;
      prev_l   = 1'b0;
      lock_len = 0;
    end else begin
      if (bus.locked) lock_len++;
      if (bus.granted && !prev_g) ev(EV_GRANT);
      if (!bus.granted && prev_g) ev(EV_LOGOUT);
      if (bus.fail_pulse) ev(EV_REJECT);
      if (!bus.locked && prev_l) begin
        ev(EV_UNLOCK);
        lock_len = 0;
      end
      prev_g = bus.granted;
      prev_l = bus.locked;
    end
  end

  // Stimulus helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_digit(input logic [3:0] d);
    bus.digit_in     = d;
    bus.digit_strobe = 1'b1;
    tick();
    bus.digit_strobe = 1'b0;
    tick();
  endtask

  task automatic enter_user(input logic [15:0] u);
    for (int i = 0; i < UD; i++) send_digit(u[15-4*i -: 4]);
  endtask

  task automatic enter_pass(input logic [19:0] p);
    for (int i = 0; i < PD; i++) send_digit(p[19-4*i -: 4]);
  endtask

  task automatic wait_pass();
    for (int i = 0; i < 40 && !bus.pass_phase; i++) tick();
    chk("pass_phase_reached", int'(bus.pass_phase), 1);
  endtask

  task automatic wait_locked();
    for (int i = 0; i < 40 && !bus.locked; i++) tick();
    chk("locked_reached", int'(bus.locked), 1);
  endtask

  task automatic login(input logic [15:0] u, input logic [19:0] p);
    enter_user(u);
    wait_pass();
    enter_pass(p);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) tick();
    chk("scoreboard_drained", sb_q.size(), 0);
  endtask

  task automatic do_logout();
    push(EV_LOGOUT, 0, 0, 0);
    bus.logout = 1'b1;
    tick();
    bus.logout = 1'b0;
    chk("granted_after_logout", int'(bus.granted), 0);
    chk("user_idx_after_logout", int'(bus.user_idx), 0);
    drain(10);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_granted"}, int'(bus.granted), 0);
    chk({tag, "_user_idx"}, int'(bus.user_idx), 0);
    chk({tag, "_fail_pulse"}, int'(bus.fail_pulse), 0);
    chk({tag, "_locked"}, int'(bus.locked), 0);
    chk({tag, "_fail_count"}, int'(bus.fail_count), 0);
    chk({tag, "_pass_phase"}, int'(bus.pass_phase), 0);
    chk({tag, "_rom_addr"}, int'(bus.rom_addr), 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.digit_in     = '0;
    bus.digit_strobe = 1'b0;
    bus.logout       = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Correct login, strobes ignored while granted, then logout
    push(EV_GRANT, 2, 0, 0);
    login(16'h1A2B, 20'h3C4D5);
    drain(20);
    chk("granted_after_login", int'(bus.granted), 1);
    send_digit(4'h9);
    send_digit(4'h9);
    chk("granted_holds", int'(bus.granted), 1);
    chk("user_idx_holds", int'(bus.user_idx), 2);
    do_logout();

    // Wrong password for a known user
    push(EV_REJECT, 0, 1, 0);
    login(16'h1A2B, 20'h00000);
    drain(20);
    chk("pass_phase_after_reject", int'(bus.pass_phase), 0);
    chk("granted_after_reject", int'(bus.granted), 0);

    // Unknown user still gets a password prompt, then rejected
    push(EV_REJECT, 0, 2, 0);
    login(16'hFFFF, 20'h12345);
    drain(20);

    // Third failure (duplicate ID: lowest index wins) locks for exactly LOCK cycles
    push(EV_REJECT, 0, 3, 1);
    push(EV_UNLOCK, 0, 0, LOCK);
    login(16'h1A2B, 20'h55555);
    wait_locked();
    enter_user(16'h1A2B);
    drain(100);
    chk("locked_after_unlock", int'(bus.locked), 0);
    chk("fail_count_after_unlock", int'(bus.fail_count), 0);
    push(EV_GRANT, 7, 0, 0);
    login(16'h7777, 20'h77777);
    drain(20);
    do_logout();

    // Reset in the middle of a search
    push(EV_REJECT, 0, 1, 0);
    login(16'h2222, 20'h99999);
    drain(20);
    enter_user(16'hFFFF);
    tick();
    tick();
    chk("pass_phase_in_search", int'(bus.pass_phase), 0);
    pulse_reset();
    check_reset_outputs("rst_search");
    push(EV_GRANT, 2, 0, 0);
    login(16'h1A2B, 20'h3C4D5);
    drain(20);
    do_logout();

    // Reset in the middle of a lockout
    push(EV_REJECT, 0, 1, 0);
    login(16'h1A2B, 20'h11111);
    drain(20);
    push(EV_REJECT, 0, 2, 0);
    login(16'h4444, 20'h00001);
    drain(20);
    push(EV_REJECT, 0, 3, 1);
    login(16'h0000, 20'h00000);
    wait_locked();
    drain(20);
    repeat (5) tick();
    pulse_reset();
    check_reset_outputs("rst_lockout");
    push(EV_GRANT, 2, 0, 0);
    login(16'h1A2B, 20'h3C4D5);
    drain(20);
    do_logout();

    // Idle partial entry
    push(EV_REJECT, 0, 1, 0);
    login(16'h1111, 20'h00000);
    drain(20);
    send_digit(4'h1);
    send_digit(4'hA);
`ifdef ACCESS_ENTRY_TIMEOUT_EN
    repeat (TMO + 2) tick();
    chk("fail_count_after_timeout", int'(bus.fail_count), 1);
    chk("pass_phase_after_timeout", int'(bus.pass_phase), 0);
    push(EV_GRANT, 2, 0, 0);
    login(16'h1A2B, 20'h3C4D5);
`else
    repeat (30) tick();
    chk("fail_count_after_idle", int'(bus.fail_count), 1);
    push(EV_GRANT, 2, 0, 0);
    send_digit(4'h2);
    send_digit(4'hB);
    wait_pass();
    enter_pass(20'h3C4D5);
`endif
    drain(20);
    do_logout();

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
